// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-addressed synchronous data memory,
// with read-modify-write for sub-word stores and big-endian lane numbering.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W+1:0] byte_addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_sel,
  output logic              mem_str,
  output logic              mem_ld,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t            state;
  logic              l_we;
  logic              l_sext;
  logic [1:0]        l_size;
  logic [1:0]        l_lane;
  logic [15:0]       l_wdata;
  logic              bad;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  always_comb begin
    bad = (size == 2'b11) ||
          (size == 2'b01 && byte_addr[0]) ||
          (size == 2'b10 && byte_addr[1:0] != 2'b00);
  end

  // Lane 0 is the most significant byte/half of the word.
  always_comb begin
    lane_byte = mem_rdata[7:0];
    case (l_lane)
      2'd0:    lane_byte = mem_rdata[31:24];
      2'd1:    lane_byte = mem_rdata[23:16];
      2'd2:    lane_byte = mem_rdata[15:8];
      default: lane_byte = mem_rdata[7:0];
    endcase
    lane_half = l_lane[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    case (l_size)
      2'b00:   load_val = {{24{l_sext & lane_byte[7]}}, lane_byte};
      2'b01:   load_val = {{16{l_sext & lane_half[15]}}, lane_half};
      default: load_val = mem_rdata;
    endcase

    merged = mem_rdata;
    if (l_size == 2'b00) begin
      case (l_lane)
        2'd0:    merged[31:24] = l_wdata[7:0];
        2'd1:    merged[23:16] = l_wdata[7:0];
        2'd2:    merged[15:8]  = l_wdata[7:0];
        default: merged[7:0]   = l_wdata[7:0];
      endcase
    end else if (l_size == 2'b01) begin
      if (l_lane[1]) merged[15:0]  = l_wdata;
      else           merged[31:16] = l_wdata;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      l_we      <= 1'b0;
      l_sext    <= 1'b0;
      l_size    <= 2'b00;
      l_lane    <= 2'b00;
      l_wdata   <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_sel   <= 1'b0;
      mem_str   <= 1'b0;
      mem_ld    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (req) begin
          l_we    <= we;
          l_sext  <= sign_ext;
          l_size  <= size;
          l_lane  <= byte_addr[1:0];
          l_wdata <= wdata[15:0];
          busy    <= 1'b1;
          if (bad) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (we && size == 2'b10) begin
            // Full-word store needs no read of the old word.
            state     <= WR;
            mem_sel   <= 1'b1;
            mem_str   <= 1'b1;
            mem_addr  <= byte_addr[ADDR_W+1:2];
            mem_wdata <= wdata;
          end else begin
            state    <= RD;
            mem_sel  <= 1'b1;
            mem_ld   <= 1'b1;
            mem_addr <= byte_addr[ADDR_W+1:2];
          end
        end
        RD: state <= CAP;
        CAP: begin
          mem_ld <= 1'b0;
          if (l_we) begin
            state     <= WR;
            mem_str   <= 1'b1;
            mem_wdata <= merged;
          end else begin
            state    <= DONE;
            rdata    <= load_val;
            mem_sel  <= 1'b0;
            mem_addr <= '0;
            done     <= 1'b1;
          end
        end
        WR: begin
          state     <= DONE;
          mem_sel   <= 1'b0;
          mem_str   <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          done      <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a reference model predicts each access at issue time,
// a monitor checks every completion, and memory contents are compared at the end.
module tb_load_store_unit;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              clr;
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W+1:0] byte_addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              mem_sel;
  logic              mem_str;
  logic              mem_ld;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .clr(clr), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .byte_addr(byte_addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .err(err), .mem_sel(mem_sel), .mem_str(mem_str), .mem_ld(mem_ld),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory seen by the DUT.
  logic [31:0] dmem [0:1023];
  logic [31:0] seed_val [0:15];
  logic        seed_mem;

  always @(posedge clk) begin
    if (seed_mem) begin
      for (int i = 0; i < 16; i++) dmem[i] <= seed_val[i];
    end else begin
      if (mem_sel && mem_ld)  mem_rdata <= dmem[mem_addr];
      if (mem_sel && mem_str) dmem[mem_addr] <= mem_wdata;
    end
  end

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          sel;
    int          str;
    int          issue;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [0:15];
  logic [31:0] ref_rdata;
  int          n_cmp;
  int          n_bad;
  bit          hold_req;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Completion monitor: counts strobe cycles per access and checks each done against the queue.
  int sel_cnt;
  int str_cnt;
  always @(negedge clk) begin
    if (clr) begin
      sel_cnt = 0;
      str_cnt = 0;
    end else begin
      if (mem_sel) sel_cnt++;
      if (mem_str) str_cnt++;
      if (err && !done) check("err_without_done", {63'd0, err}, 64'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {63'd0, done}, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("err",      {63'd0, err}, {63'd0, e.err});
          check("rdata",    {32'd0, rdata}, {32'd0, e.rdata});
          check("latency",  64'(cyc - e.issue), 64'(e.lat));
          check("sel_cycles", 64'(sel_cnt), 64'(e.sel));
          check("str_cycles", 64'(str_cnt), 64'(e.str));
        end
        sel_cnt = 0;
        str_cnt = 0;
      end
    end
  end

  task automatic drive_garbage();
    req       = hold_req ? 1'b1 : 1'($urandom);
    we        = 1'($urandom);
    size      = 2'($urandom);
    sign_ext  = 1'($urandom);
    byte_addr = 12'($urandom);
    wdata     = $urandom;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 20) begin
      drive_garbage();
      @(negedge clk);
      g++;
    end
    if (busy) check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic idle_cycles(input int n);
    wait_idle();
    req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Issue one access at the next IDLE cycle; the model predicts the completion from first principles.
  task automatic run_access(input bit w, input logic [1:0] sz, input bit sx,
                            input logic [11:0] a, input logic [31:0] wd, input bit commit);
    exp_t        e;
    bit          bad;
    int          idx;
    int          lane;
    int          sh;
    logic [31:0] word;
    logic [31:0] v;
    logic [31:0] mask;
    wait_idle();
    req = 1'b1; we = w; size = sz; sign_ext = sx; byte_addr = a; wdata = wd;
    bad  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    idx  = int'(a[11:2]);
    lane = int'(a[1:0]);
    if (bad) begin
      e.lat = 1; e.sel = 0; e.str = 0;
    end else if (!w) begin
      e.lat = 3; e.sel = 2; e.str = 0;
      word = ref_mem[idx];
      if (sz == 2'd2) begin
        v = word;
      end else if (sz == 2'd0) begin
        v = (word >> (8 * (3 - lane))) & 32'hFF;
        if (sx && v[7]) v = v | 32'hFFFF_FF00;
      end else begin
        v = (word >> (16 * (1 - lane / 2))) & 32'hFFFF;
        if (sx && v[15]) v = v | 32'hFFFF_0000;
      end
      if (commit) ref_rdata = v;
    end else if (sz == 2'd2) begin
      e.lat = 2; e.sel = 1; e.str = 1;
      if (commit) ref_mem[idx] = wd;
    end else begin
      e.lat = 4; e.sel = 3; e.str = 1;
      if (sz == 2'd0) begin
        sh   = 8 * (3 - lane);
        mask = 32'hFF << sh;
      end else begin
        sh   = 16 * (1 - lane / 2);
        mask = 32'hFFFF << sh;
      end
      if (commit) ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd << sh) & mask);
    end
    e.err   = bad;
    e.rdata = ref_rdata;
    e.issue = cyc;
    if (commit) exp_q.push_back(e);
    @(negedge clk);
    drive_garbage();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; hold_req = 0; ref_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      seed_val[i] = $urandom;
      ref_mem[i]  = seed_val[i];
    end
    clr = 1'b1; seed_mem = 1'b1;
    req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0; byte_addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    seed_mem = 1'b0;
    check("reset_outputs", {rdata, busy, done, err, mem_sel, mem_str, mem_ld, 6'd0},
          64'd0);
    check("reset_mem_bus", {12'd0, mem_addr, mem_wdata, 10'd0}, 64'd0);
    clr = 1'b0;

    // Word store then word load.
    run_access(1, 2'b10, 0, 12'h028, 32'hDEADBEEF, 1);
    run_access(0, 2'b10, 0, 12'h028, 32'h0, 1);
    idle_cycles(1);
    check("lw_deadbeef", {32'd0, rdata}, 64'hDEADBEEF);

    // Byte store read-modify-write.
    run_access(1, 2'b00, 0, 12'h029, 32'h1234_5655, 1);
    idle_cycles(1);
    check("sb_word10", {32'd0, dmem[10]}, 64'hDE55BEEF);

    run_access(0, 2'b00, 1, 12'h02A, 32'h0, 1);
    idle_cycles(1);
    check("lb_sign", {32'd0, rdata}, 64'hFFFFFFBE);
    run_access(0, 2'b00, 0, 12'h02A, 32'h0, 1);
    idle_cycles(1);
    check("lbu", {32'd0, rdata}, 64'h000000BE);
    run_access(0, 2'b01, 1, 12'h028, 32'h0, 1);
    idle_cycles(1);
    check("lh_sign", {32'd0, rdata}, 64'hFFFFDE55);
    run_access(0, 2'b01, 0, 12'h02A, 32'h0, 1);
    idle_cycles(1);
    check("lhu", {32'd0, rdata}, 64'h0000BEEF);

    // Misaligned word load and half store, plus a reserved size.
    run_access(0, 2'b10, 0, 12'h029, 32'h0, 1);
    run_access(1, 2'b01, 0, 12'h02B, 32'hAAAA_AAAA, 1);
    run_access(0, 2'b11, 1, 12'h028, 32'h0, 1);
    idle_cycles(1);
    check("err_rdata_kept", {32'd0, rdata}, 64'h0000BEEF);
    check("err_mem_kept", {32'd0, dmem[10]}, 64'hDE55BEEF);

    // Back-to-back with req held high; inputs scrambled while busy.
    hold_req = 1;
    for (int i = 0; i < 8; i++)
      run_access(1'($urandom), 2'($urandom), 1'($urandom), {6'd0, 4'($urandom), 2'($urandom)},
                 $urandom, 1);
    hold_req = 0;
    idle_cycles(2);

    // Reset during RD of a byte store: no write, everything cleared.
    ref_mem[10] = dmem[10];
    run_access(1, 2'b00, 0, 12'h029, 32'h0000_0011, 0);
    #2 clr = 1'b1;
    req = 1'b0;
    #1;
    check("abort_outputs", {rdata, busy, done, err, mem_sel, mem_str, mem_ld, 6'd0}, 64'd0);
    check("abort_mem_bus", {12'd0, mem_addr, mem_wdata, 10'd0}, 64'd0);
    ref_rdata = '0;
    @(negedge clk);
    #2 clr = 1'b0;
    @(negedge clk);
    run_access(0, 2'b10, 0, 12'h028, 32'h0, 1);
    idle_cycles(1);
    check("abort_load_old", {32'd0, rdata}, {32'd0, ref_mem[10]});

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      run_access(1'($urandom), 2'($urandom), 1'($urandom), {6'd0, 4'($urandom), 2'($urandom)},
                 $urandom, 1);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(0, 3));
    end
    idle_cycles(2);

    for (int g = 0; g < 20 && exp_q.size() != 0; g++) @(negedge clk);
    check("pending_completions", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 16; i++) check($sformatf("mem_word%0d", i), {32'd0, dmem[i]}, {32'd0, ref_mem[i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: ADDR_W, 10, word-address width of data_memory.
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: clr  in  1  asynchronous active-high reset.
REQ-004 SHALL have port: req  in  1  start one access; sampled only in IDLE.
REQ-005 SHALL have port: we  in  1  1 = store, 0 = load.
REQ-006 SHALL have port: size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 SHALL have port: sign_ext  in  1  loads: 1 sign-extend, 0 zero-extend.
REQ-008 SHALL have port: byte_addr  in  ADDR_W+2  byte address; [ADDR_W+1:2] word index, [1:0] lane.
REQ-009 SHALL have port: wdata  in  32  store data, right-justified.
REQ-010 SHALL have port: rdata  out  32  load result.
REQ-011 SHALL have port: busy  out  1  high whenever state != IDLE.
REQ-012 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port: err  out  1  one-cycle misalignment/reserved-size pulse, coincident with done.
REQ-014 SHALL have ports to data_memory: mem_sel out 1, mem_str out 1, mem_ld out 1, mem_addr out ADDR_W, mem_wdata out 32, mem_rdata in 32.

Function
REQ-015 SHALL implement states IDLE, RD, CAP, WR, DONE.
REQ-016 SHALL, in IDLE on req=1, latch we/size/sign_ext/byte_addr/wdata; later input changes have no effect on the access.
REQ-017 SHALL treat as error: size=11; size=01 with byte_addr[0]=1; size=10 with byte_addr[1:0]!=00. Error -> DONE next cycle, err=1, no memory strobe, rdata unchanged.
REQ-018 SHALL sequence: load IDLE->RD->CAP->DONE; word store IDLE->WR->DONE; byte/half store IDLE->RD->CAP->WR->DONE; DONE->IDLE always.
REQ-019 SHALL drive mem_sel=mem_ld=1 in RD and CAP, mem_sel=mem_str=1 in WR, all mem strobes 0 in IDLE and DONE.
REQ-020 SHALL hold mem_addr = latched byte_addr[ADDR_W+1:2] in RD/CAP/WR, 0 otherwise.
REQ-021 SHALL capture mem_rdata at the clock edge ending CAP.
REQ-022 SHALL use big-endian lanes: byte offset 0 = bits 31:24, 3 = bits 7:0; half offset 0 = bits 31:16, 2 = bits 15:0.
REQ-023 SHALL, on load, write rdata at the edge ending CAP: selected lane extended to 32 bits per sign_ext; word loads pass unchanged.
REQ-024 SHALL, on sub-word store, set mem_wdata in WR to captured word with only the addressed lane replaced by wdata[7:0] or wdata[15:0]; word store drives wdata; mem_wdata = 0 outside WR.
REQ-025 SHALL leave rdata unchanged by stores and errors.
REQ-026 SHALL assert done (and err if applicable) only in DONE; done is cycle N+3 for loads, N+2 word stores, N+4 sub-word stores, N+1 errors, N = req-sampling cycle.
REQ-027 SHALL ignore req while busy=1, including in DONE; earliest next acceptance is the IDLE cycle after done.

Reset
REQ-028 SHALL, on clr=1 asynchronously, enter IDLE and force rdata=0, busy=0, done=0, err=0, all mem_* outputs 0.
REQ-029 SHALL abort any in-flight access on clr; an aborted store whose WR edge has not occurred leaves memory unwritten.
REQ-030 SHALL accept req from the first rising edge with clr=0.

Verification
REQ-031 Word store/load: store 0xDEADBEEF at byte_addr 0x028, then load word -> rdata=0xDEADBEEF, done 3 cycles after req, err=0.
REQ-032 Byte store RMW: word 10 = 0xDEADBEEF, store byte 0x55 at 0x029 -> word 10 = 0xDE55BEEF, exactly one mem_str cycle, done at N+4.
REQ-033 Sub-word loads on 0xDE55BEEF: lb 0x02A sign -> 0xFFFFFFBE; lbu 0x02A -> 0x000000BE; lh 0x028 -> 0xFFFFDE55; lhu 0x02A -> 0x0000BEEF.
REQ-034 Misalignment: lw at 0x029 and sh at 0x02B -> err=done=1 at N+1, mem_sel never high, rdata and memory unchanged.
REQ-035 Busy/req: req held high continuously -> each access completes before the next starts; inputs changed mid-access do not alter the result.
REQ-036 Reset mid-store: clr in RD of byte store to 0x029 -> outputs 0 immediately, word 10 unchanged, next load returns old value.
